// File: rtl/add_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_pkg
// Description : Shared types and default timing constants for the serial
//               adder and its feeder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package add_serial_pkg;

    // Feeder sequencer states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // One load cycle plus eight add cycles before add_out is valid.
    localparam int unsigned c_dflt_result_lat = 9;
    // Idle cycles after capture so the adder can return to its idle state.
    localparam int unsigned c_dflt_gap_cyc    = 2;

endpackage : add_serial_pkg
`default_nettype wire

// File: rtl/add_serial_opfifo.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_opfifo
// Description : Small synchronous FIFO holding operand pairs. DEPTH must be a
//               power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module add_serial_opfifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // A full FIFO never accepts, even if a pop happens in the same cycle.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array; contents need no reset since the count qualifies them.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full     = (r_count == c_depth);
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

endmodule : add_serial_opfifo
`default_nettype wire

// File: rtl/add_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_feeder
// Description : Sequencer around one serial adder. Buffers operand pairs,
//               launches them one at a time, captures add_out after a fixed
//               latency and returns each sum on a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module add_serial_feeder
    import add_serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int RESULT_LAT = int'(c_dflt_result_lat),
    parameter int GAP_CYC    = int'(c_dflt_gap_cyc)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             busy
);

    localparam int c_cnt_w = $clog2(RESULT_LAT + GAP_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_lat_last = c_cnt_w'(RESULT_LAT);
    // GAP_CYC is expected to be >= 2; the S_GAP stay plus the S_IDLE cycle
    // together make up the gap.
    localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP_CYC - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_add_en;
    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_sum;

    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [2*WIDTH-1:0] w_head;
    logic               w_res_take;
    logic               w_launch;
    logic [c_cnt_w-1:0] w_cnt_inc;

    assign in_ready   = !w_full;
    assign w_push     = in_valid && in_ready;
    assign w_res_take = r_res_valid && res_ready;
    // A result being dequeued this cycle frees the slot for a same-cycle launch.
    assign w_launch   = (r_state == S_IDLE) && !w_empty && (!r_res_valid || res_ready);
    assign w_cnt_inc  = r_cnt + 1'b1;

    add_serial_opfifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_opfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({in_a, in_b}),
        .pop       (w_launch),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Launch / wait / capture / gap sequencing with registered adder and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_add_en    <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
        end else begin
            r_add_en <= 1'b0;
            if (w_res_take) begin
                r_res_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_launch) begin
                        r_add_a  <= w_head[2*WIDTH-1:WIDTH];
                        r_add_b  <= w_head[WIDTH-1:0];
                        r_add_en <= 1'b1;
                        r_state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= c_cnt_one;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == c_lat_last) begin
                        r_res_sum   <= add_out;
                        r_res_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_GAP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_GAP: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= c_gap_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign add_en    = r_add_en;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign busy      = (r_state != S_IDLE);

endmodule : add_serial_feeder
`default_nettype wire

// File: tb/tb_add_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_serial_feeder
// Description : Scoreboard bench for add_serial_feeder with a behavioural
//               serial-adder stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_serial_feeder;

    localparam int W      = 8;
    localparam int DEPTH  = 2;
    localparam int LAT    = 9;
    localparam int GAP    = 2;
    localparam int PERIOD = 1 + LAT + GAP;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         add_en;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_out = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_sum;
    logic         busy;

    always #5 clk = ~clk;

    add_serial_feeder #(
        .WIDTH      (W),
        .FIFO_DEPTH (DEPTH),
        .RESULT_LAT (LAT),
        .GAP_CYC    (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .busy      (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial adder stand-in: sum appears on add_out only after LAT-1 add
    // cycles following the load edge; before that the bus carries noise.
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           m_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
        end else if (add_en) begin
            m_a     <= add_a;
            m_b     <= add_b;
            m_cnt   <= 1;
            add_out <= W'($urandom);
        end else if (m_cnt > 0 && m_cnt < LAT) begin
            m_cnt   <= m_cnt + 1;
            add_out <= (m_cnt == LAT - 1) ? W'((int'(m_a) + int'(m_b)) % 256) : W'($urandom);
        end
    end

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           rr_mode = 0;     // 0: always ready, 1: random, 2: never ready
    bit           gap_arm = 1'b0;
    int           acc_cyc = 0;
    int           en_pulses = 0;
    int           p0 = 0;
    int           t = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Offer one pair starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int k = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("send_accepted", int'(in_ready), 1);
        if (in_ready) begin
            exp_q.push_back(W'((int'(a) + int'(b)) % 256));
            acc_cyc = cyc + 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic set_mode(input int m);
        @(posedge clk);
        #1 rr_mode = m;
        @(negedge clk);
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit           prev_en = 1'b0;
    bit           prev_rv = 1'b0;
    bit           have_cap = 1'b0;
    bit           have_en = 1'b0;
    int           t_cap = 0;
    int           t_en = 0;
    logic [W-1:0] e;

    initial begin
        fork
            begin : stimulus
                // Reset state
                repeat (3) @(negedge clk);
                chk("rst_in_ready", int'(in_ready), 1);
                chk("rst_add_en", int'(add_en), 0);
                chk("rst_add_a", int'(add_a), 0);
                chk("rst_add_b", int'(add_b), 0);
                chk("rst_res_valid", int'(res_valid), 0);
                chk("rst_res_sum", int'(res_sum), 0);
                chk("rst_busy", int'(busy), 0);
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);

                // Single op and accept-to-valid latency
                send(8'h35, 8'h4A);
                t = 0;
                while (!res_valid && t < 40) begin
                    @(negedge clk);
                    t++;
                end
                chk("single_latency", cyc - acc_cyc, LAT + 2);
                repeat (15) @(negedge clk);

                // Overflow wraps, carry dropped
                send(8'hFF, 8'h01);
                repeat (20) @(negedge clk);
                chk("overflow_drained", exp_q.size(), 0);

                // FIFO full with back-to-back ops; gap and period checked by monitor
                gap_arm = 1'b1;
                send(8'h10, 8'h20);
                send(8'hC3, 8'h5A);
                send(8'h80, 8'h80);
                chk("fifo_full_in_ready", int'(in_ready), 0);
                wait_drain(100);
                repeat (5) @(negedge clk);
                gap_arm = 1'b0;

                // Backpressure: one result held, no further launch
                set_mode(2);
                p0 = en_pulses;
                send(8'h11, 8'h22);
                send(8'h7F, 8'h01);
                repeat (30) @(negedge clk);
                chk("bp_one_launch", en_pulses - p0, 1);
                chk("bp_res_held", int'(res_valid), 1);
                chk("bp_fifo_one_left", int'(in_ready), 1);
                set_mode(0);
                @(negedge clk);
                chk("bp_same_cycle_launch", int'(add_en), 1);
                chk("bp_slot_freed", int'(res_valid), 0);
                wait_drain(60);
                repeat (5) @(negedge clk);

                // Reset in the middle of an operation
                send(8'h01, 8'h02);
                send(8'h03, 8'h04);
                t = 0;
                while (!add_en && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                chk("mid_rst_launch_seen", int'(add_en), 1);
                repeat (4) @(posedge clk);
                #1 rst = 1'b1;
                exp_q.delete();
                @(posedge clk);
                #1;
                chk("mid_rst_busy", int'(busy), 0);
                chk("mid_rst_res_valid", int'(res_valid), 0);
                chk("mid_rst_in_ready", int'(in_ready), 1);
                chk("mid_rst_add_en", int'(add_en), 0);
                rst = 1'b0;
                p0 = en_pulses;
                repeat (40) @(negedge clk);
                chk("mid_rst_no_stale_launch", en_pulses - p0, 0);

                // Randomised traffic with random result backpressure
                set_mode(1);
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(W'($urandom), W'($urandom));
                end
                wait_drain(3000);
                set_mode(0);
                repeat (20) @(negedge clk);
                chk("final_empty", exp_q.size(), 0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    case (rr_mode)
                        0:       res_ready = 1'b1;
                        1:       res_ready = ($urandom_range(0, 2) != 0);
                        default: res_ready = 1'b0;
                    endcase
                    if (!rst) begin
                        if (res_valid && res_ready) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_result: actual sum 0x%0h required none at cycle %0d",
                                         res_sum, cyc);
                            end else begin
                                e = exp_q.pop_front();
                                chk("res_sum", int'(res_sum), int'(e));
                            end
                        end
                        if (prev_en) begin
                            chk("add_en_one_cycle", int'(add_en), 0);
                        end
                        if (add_en && !prev_en) begin
                            en_pulses++;
                            chk("launch_while_res_valid", int'(res_valid), 0);
                            if (gap_arm && have_cap) chk("gap_cycles", cyc - t_cap, GAP);
                            if (gap_arm && have_en)  chk("launch_period", cyc - t_en, PERIOD);
                            t_en     = cyc;
                            have_en  = 1'b1;
                            have_cap = 1'b0;
                        end
                        if (res_valid && !prev_rv) begin
                            t_cap    = cyc;
                            have_cap = 1'b1;
                        end
                        if (m_cnt >= 1 && m_cnt < LAT) begin
                            chk("add_a_stable", int'(add_a), int'(m_a));
                            chk("add_b_stable", int'(add_b), int'(m_b));
                        end
                    end
                    if (!gap_arm) begin
                        have_cap = 1'b0;
                        have_en  = 1'b0;
                    end
                    prev_en = add_en;
                    prev_rv = res_valid;
                end
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_add_serial_feeder
`default_nettype wire
